load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 42 ++++
 rtl/load_store_unit.sv | 214 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bundle of the EX-side request, data-memory and writeback signals of the load/store unit.
// The slave modport is the LSU itself; the master modport is the pipeline/memory side.
interface load_store_unit_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  logic        rsp_valid_o;
  logic        rsp_wb_o;
  logic [4:0]  rsp_rd_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_misalign_o;

  modport slave (
    input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    output rsp_valid_o, rsp_wb_o, rsp_rd_o, rsp_rdata_o, rsp_misalign_o
  );

  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, req_rd_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
    input  rsp_valid_o, rsp_wb_o, rsp_rd_o, rsp_rdata_o, rsp_misalign_o
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one memory operation in flight, byte-lane steering and load extension.
// Optional LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses skip memory and report rsp_misalign_o.
//
// state | meaning
// IDLE  | ready for a new op from EX
// REQ   | mem_req_o asserted, waiting for mem_gnt_i (or misalign trap response)
// WAIT  | load granted, waiting for mem_rvalid_i
// RESP  | one-cycle rsp_valid_o to writeback
module load_store_unit (
  input logic clk_i,
  input logic rst_i,
  load_store_unit_if.slave lsu
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offs_q;
  logic [4:0]  rd_q;

  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic        rsp_valid_q;
  logic        rsp_wb_q;
  logic [4:0]  rsp_rd_q;
  logic [31:0] rsp_rdata_q;

  size_t       req_size;

  // Undefined funct3 encodings fall through to a word access.
  function automatic size_t op_size(input logic we, input logic [2:0] f3);
    size_t s;
    s = SZ_W;
    if (we) begin
      case (f3)
        3'b000:  s = SZ_B;
        3'b001:  s = SZ_H;
        default: s = SZ_W;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: s = SZ_B;
        3'b001, 3'b101: s = SZ_H;
        default:        s = SZ_W;
      endcase
    end
    return s;
  endfunction

  function automatic logic [3:0] lane_be(input size_t s, input logic [1:0] offs);
    logic [3:0] be;
    case (s)
      SZ_B:    be = 4'b0001 << offs;
      SZ_H:    be = offs[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input size_t s, input logic [31:0] wdata);
    logic [31:0] d;
    case (s)
      SZ_B:    d = {4{wdata[7:0]}};
      SZ_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Halfword lane selection uses only offs[1], so an odd halfword address reads the aligned-down half.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] offs,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (offs)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = offs[1] ? rdata[31:16] : rdata[15:0];
    case (op_size(1'b0, f3))
      SZ_B:    r = f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    r = f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  logic rsp_misalign_q;

  function automatic logic is_misaligned(input size_t s, input logic [1:0] offs);
    logic m;
    case (s)
      SZ_H:    m = offs[0];
      SZ_W:    m = (offs != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  assign lsu.rsp_misalign_o = rsp_misalign_q;
`else
  assign lsu.rsp_misalign_o = 1'b0;
`endif

  assign req_size = op_size(lsu.req_we_i, lsu.req_funct3_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      offs_q      <= 2'b00;
      rd_q        <= 5'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_wb_q    <= 1'b0;
      rsp_rd_q    <= 5'd0;
      rsp_rdata_q <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q     <= 1'b0;
      rsp_misalign_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (lsu.req_valid_i) begin
            we_q        <= lsu.req_we_i;
            funct3_q    <= lsu.req_funct3_i;
            offs_q      <= lsu.req_addr_i[1:0];
            rd_q        <= lsu.req_rd_i;
            mem_we_q    <= lsu.req_we_i;
            mem_addr_q  <= {lsu.req_addr_i[31:2], 2'b00};
            mem_be_q    <= lane_be(req_size, lsu.req_addr_i[1:0]);
            mem_wdata_q <= lane_wdata(req_size, lsu.req_wdata_i);
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q  <= is_misaligned(req_size, lsu.req_addr_i[1:0]);
            mem_req_q   <= !is_misaligned(req_size, lsu.req_addr_i[1:0]);
`else
            mem_req_q   <= 1'b1;
`endif
            state       <= REQ;
          end
        end
        REQ: begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (misalign_q) begin
            rsp_valid_q    <= 1'b1;
            rsp_wb_q       <= 1'b0;
            rsp_misalign_q <= 1'b1;
            rsp_rd_q       <= rd_q;
            state          <= RESP;
          end else
`endif
          if (lsu.mem_gnt_i) begin
            mem_req_q <= 1'b0;
            if (we_q) begin
              rsp_valid_q <= 1'b1;
              rsp_wb_q    <= 1'b0;
              rsp_rd_q    <= rd_q;
              state       <= RESP;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (lsu.mem_rvalid_i) begin
            rsp_rdata_q <= load_extend(funct3_q, offs_q, lsu.mem_rdata_i);
            rsp_valid_q <= 1'b1;
            rsp_wb_q    <= 1'b1;
            rsp_rd_q    <= rd_q;
            state       <= RESP;
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          rsp_wb_q    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
          rsp_misalign_q <= 1'b0;
`endif
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lsu.req_ready_o = (state == IDLE);
  assign lsu.mem_req_o   = mem_req_q;
  assign lsu.mem_we_o    = mem_we_q;
  assign lsu.mem_addr_o  = mem_addr_q;
  assign lsu.mem_be_o    = mem_be_q;
  assign lsu.mem_wdata_o = mem_wdata_q;
  assign lsu.rsp_valid_o = rsp_valid_q;
  assign lsu.rsp_wb_o    = rsp_wb_q;
  assign lsu.rsp_rd_o    = rsp_rd_q;
  assign lsu.rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected responses are queued when an op is issued
// and compared when rsp_valid_o appears; memory-side outputs are checked every REQ cycle.
module tb_load_store_unit;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .lsu   (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd);
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_funct3_i = f3;
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wdata;
    bus.req_rd_i     = rd;
  endtask

  // Waits (bounded) for rsp_valid_o, checks it arrived on the expected cycle, then scores it.
  task automatic collect_rsp(input string tag);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk_i);
    while (bus.rsp_valid_o !== 1'b1 && n < 8) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, " rsp_latency"}, n, 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " rsp_wb"}, {31'h0, bus.rsp_wb_o}, {31'h0, e.wb});
      chk({tag, " rsp_rd"}, {27'h0, bus.rsp_rd_o}, {27'h0, e.rd});
      chk({tag, " rsp_rdata"}, bus.rsp_rdata_o, e.rdata);
      chk({tag, " rsp_misalign"}, {31'h0, bus.rsp_misalign_o}, {31'h0, e.mis});
    end else begin
      chk({tag, " scoreboard_nonempty"}, 32'd0, 32'd1);
    end
    @(negedge clk_i);
    chk({tag, " rsp_one_cycle"}, {31'h0, bus.rsp_valid_o}, 32'd0);
    chk({tag, " rdata_hold"}, bus.rsp_rdata_o, e.rdata);
    chk({tag, " ready_after"}, {31'h0, bus.req_ready_o}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] rdata, input int gwait,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    exp_t e;
    e.wb  = !we;
    e.rd  = rd;
    e.mis = 1'b0;
    if (!we) last_rdata = e_rdata;
    e.rdata = last_rdata;
    sb.push_back(e);

    @(posedge clk_i); #1;
    chk({tag, " ready"}, {31'h0, bus.req_ready_o}, 32'd1);
    drive_req(we, f3, addr, wdata, rd);
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom;
    bus.req_wdata_i = $urandom;
    for (int k = 0; k <= gwait; k++) begin
      @(negedge clk_i);
      chk({tag, " mem_req"}, {31'h0, bus.mem_req_o}, 32'd1);
      chk({tag, " mem_we"}, {31'h0, bus.mem_we_o}, {31'h0, we});
      chk({tag, " mem_addr"}, bus.mem_addr_o, e_addr);
      chk({tag, " mem_be"}, {28'h0, bus.mem_be_o}, {28'h0, e_be});
      if (we) chk({tag, " mem_wdata"}, bus.mem_wdata_o, e_wdata);
      bus.mem_gnt_i    = (k == gwait);
      // Stray rvalid while still in REQ must be ignored.
      bus.mem_rvalid_i = (k < gwait);
      bus.mem_rdata_i  = $urandom;
      @(posedge clk_i); #1;
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
    end
    if (!we) begin
      @(negedge clk_i);
      chk({tag, " wait_no_req"}, {31'h0, bus.mem_req_o}, 32'd0);
      chk({tag, " wait_no_rsp"}, {31'h0, bus.rsp_valid_o}, 32'd0);
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = rdata;
      @(posedge clk_i); #1;
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = $urandom;
    end
    collect_rsp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b1;
    bus.req_funct3_i = 3'b010;
    bus.req_addr_i   = 32'h0000_0040;
    bus.req_wdata_i  = 32'h1111_2222;
    bus.req_rd_i     = 5'd3;
    bus.mem_gnt_i    = 1'b1;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = 32'h0;

    // Reset with a request and grant presented: nothing may be captured.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst mem_req", {31'h0, bus.mem_req_o}, 32'd0);
    chk("rst mem_we", {31'h0, bus.mem_we_o}, 32'd0);
    chk("rst mem_addr", bus.mem_addr_o, 32'h0);
    chk("rst mem_be", {28'h0, bus.mem_be_o}, 32'h0);
    chk("rst mem_wdata", bus.mem_wdata_o, 32'h0);
    chk("rst rsp_valid", {31'h0, bus.rsp_valid_o}, 32'd0);
    chk("rst rsp_wb", {31'h0, bus.rsp_wb_o}, 32'd0);
    chk("rst rsp_misalign", {31'h0, bus.rsp_misalign_o}, 32'd0);
    chk("rst rsp_rdata", bus.rsp_rdata_o, 32'h0);
    chk("rst rsp_rd", {27'h0, bus.rsp_rd_o}, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.mem_gnt_i   = 1'b0;
    @(negedge clk_i);
    chk("post_rst ready", {31'h0, bus.req_ready_o}, 32'd1);
    @(negedge clk_i);
    chk("post_rst no_req", {31'h0, bus.mem_req_o}, 32'd0);

    //     tag          we    f3      addr          wdata         rd  rdata         gw  e_addr        e_be     e_wdata       e_rdata
    run_op("sw_0x100",  1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd1, 32'h0,        0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    run_op("sb_0x103",  1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 5'd2, 32'h0,        0, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    run_op("lb_0x202",  1'b0, 3'b000, 32'h0000_0202, 32'h0,         5'd5, 32'h0080_0000, 0, 32'h0000_0200, 4'b0100, 32'h0,        32'hFFFF_FF80);
    run_op("sh_0x102",  1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 5'd3, 32'h0,        1, 32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    run_op("lbu_0x202", 1'b0, 3'b100, 32'h0000_0202, 32'h0,         5'd6, 32'h0080_0000, 0, 32'h0000_0200, 4'b0100, 32'h0,        32'h0000_0080);
    run_op("lb_0x201",  1'b0, 3'b000, 32'h0000_0201, 32'h0,         5'd8, 32'h0000_7F00, 0, 32'h0000_0200, 4'b0010, 32'h0,        32'h0000_007F);
    run_op("lh_0x300",  1'b0, 3'b001, 32'h0000_0300, 32'h0,         5'd7, 32'h1234_8001, 3, 32'h0000_0300, 4'b0011, 32'h0,        32'hFFFF_8001);
    run_op("lhu_0x302", 1'b0, 3'b101, 32'h0000_0302, 32'h0,         5'd9, 32'h9ABC_0000, 0, 32'h0000_0300, 4'b1100, 32'h0,        32'h0000_9ABC);
    run_op("lw_0x404",  1'b0, 3'b010, 32'h0000_0404, 32'h0,         5'd10, 32'hCAFE_F00D, 2, 32'h0000_0404, 4'b1111, 32'h0,       32'hCAFE_F00D);
    run_op("sw_hold",   1'b1, 3'b010, 32'h0000_0408, 32'h0BAD_F00D, 5'd4, 32'h0,        0, 32'h0000_0408, 4'b1111, 32'h0BAD_F00D, 32'h0);
    run_op("ld_f3_011", 1'b0, 3'b011, 32'h0000_0500, 32'h0,         5'd11, 32'h1122_3344, 0, 32'h0000_0500, 4'b1111, 32'h0,       32'h1122_3344);
    run_op("st_f3_100", 1'b1, 3'b100, 32'h0000_0600, 32'h0000_00FF, 5'd12, 32'h0,       0, 32'h0000_0600, 4'b1111, 32'h0000_00FF, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
    begin
      exp_t e;
      e.wb = 1'b0; e.rd = 5'd13; e.rdata = last_rdata; e.mis = 1'b1;
      sb.push_back(e);
      @(posedge clk_i); #1;
      drive_req(1'b0, 3'b010, 32'h0000_0102, 32'h0, 5'd13);
      @(posedge clk_i); #1;
      bus.req_valid_i = 1'b0;
      @(negedge clk_i);
      chk("trap_lw no_mem_req", {31'h0, bus.mem_req_o}, 32'd0);
      chk("trap_lw no_early_rsp", {31'h0, bus.rsp_valid_o}, 32'd0);
      collect_rsp("trap_lw");
      chk("trap_lw still_no_req", {31'h0, bus.mem_req_o}, 32'd0);

      e.rd = 5'd14;
      sb.push_back(e);
      @(posedge clk_i); #1;
      drive_req(1'b1, 3'b001, 32'h0000_0101, 32'h0000_5555, 5'd14);
      @(posedge clk_i); #1;
      bus.req_valid_i = 1'b0;
      @(negedge clk_i);
      chk("trap_sh no_mem_req", {31'h0, bus.mem_req_o}, 32'd0);
      collect_rsp("trap_sh");
    end
`else
    run_op("lw_0x102_al", 1'b0, 3'b010, 32'h0000_0102, 32'h0, 5'd13, 32'h8765_4321, 0, 32'h0000_0100, 4'b1111, 32'h0, 32'h8765_4321);
    run_op("lh_0x301_al", 1'b0, 3'b001, 32'h0000_0301, 32'h0, 5'd14, 32'hAAAA_FFFE, 0, 32'h0000_0300, 4'b0011, 32'h0, 32'hFFFF_FFFE);
`endif

    // Reset while a load sits in WAIT: no response, late rvalid ignored.
    @(posedge clk_i); #1;
    drive_req(1'b0, 3'b001, 32'h0000_0300, 32'h0, 5'd15);
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;
    @(negedge clk_i);
    bus.mem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    bus.mem_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("rst_wait in_wait", {31'h0, bus.req_ready_o}, 32'd0);
    rst_i = 1'b1;
    #1;
    chk("rst_wait async_ready", {31'h0, bus.req_ready_o}, 32'd1);
    chk("rst_wait async_addr", bus.mem_addr_o, 32'h0);
    chk("rst_wait async_be", {28'h0, bus.mem_be_o}, 32'h0);
    chk("rst_wait async_rdata", bus.rsp_rdata_o, 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    last_rdata = 32'h0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0000_1234;
    @(posedge clk_i); #1;
    bus.mem_rvalid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("rst_wait no_rsp", {31'h0, bus.rsp_valid_o}, 32'd0);
      chk("rst_wait no_req", {31'h0, bus.mem_req_o}, 32'd0);
      chk("rst_wait ready", {31'h0, bus.req_ready_o}, 32'd1);
    end
    chk("rst_wait rdata_cleared", bus.rsp_rdata_o, 32'h0);

    // The unit still works after the abandoned transaction.
    run_op("lb_after_rst", 1'b0, 3'b000, 32'h0000_0703, 32'h0, 5'd16, 32'hF100_0000, 0, 32'h0000_0700, 4'b1000, 32'h0, 32'hFFFF_FFF1);

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
